// File: rtl/cmi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmi_pkg
// Brief    : Shared types and widths for the CMI receive-path link supervisor.
// Revision : 1.0
// ============================================================================
package cmi_pkg;

  localparam int CMI_PKT_W = 72;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RESYNC = 2'd1,
    ST_HUNT   = 2'd2,
    ST_UP     = 2'd3
  } link_state_e;

  typedef struct packed {
    logic [7:0]  head;
    logic [63:0] data;
  } cmi_pkt_t;

endpackage
`default_nettype wire

// File: rtl/cmi_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmi_pkt_fifo
// Brief    : Synchronous packet FIFO with flush; push is accepted when full
//            if a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module cmi_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/cmi_link_sup.sv
`default_nettype none
// ============================================================================
// Module   : cmi_link_sup
// Brief    : CMI link supervisor: decoder sequencing, link qualification,
//            packet buffering towards one consumer and link statistics.
// Revision : 1.0
// ============================================================================
module cmi_link_sup
  import cmi_pkg::*;
#(
  parameter int UP_CNT      = 4,
  parameter int DOWN_FAULTS = 3,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr_cnt,
  input  logic        cmi_rdy,
  input  logic        cmi_fault,
  input  logic [7:0]  cmi_head,
  input  logic [63:0] cmi_data,
  input  logic        marker_st,
  input  logic [1:0]  marker_type,
  output logic        rcv_rst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_head,
  output logic [63:0] out_data,
  output logic        link_up,
  output logic [1:0]  link_state,
  output logic        link_timeout,
  output logic [15:0] good_cnt,
  output logic [15:0] fault_cnt,
  output logic [7:0]  ovf_cnt,
  output logic [1:0]  last_marker
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  link_state_e r_state;
  link_state_e w_state_nx;
  logic [TW-1:0] r_timer;
  logic          r_rs_cnt;
  logic [3:0]    r_good_run;
  logic [3:0]    r_fault_run;
  logic          r_link_timeout;
  logic [15:0]   r_good_cnt;
  logic [15:0]   r_fault_cnt;
  logic [7:0]    r_ovf_cnt;
  logic [1:0]    r_last_marker;

  logic     w_live, w_fault, w_good, w_activity, w_timeout;
  logic     w_hunt_done, w_fault_down;
  logic     w_push, w_pop, w_drop, w_flush, w_full, w_empty;
  cmi_pkt_t w_in_pkt, w_head_pkt;

  // Packet events only count while enabled and the decoder is out of reset.
  assign w_live       = en && ((r_state == ST_HUNT) || (r_state == ST_UP));
  assign w_fault      = w_live && cmi_fault;
  assign w_good       = w_live && cmi_rdy && !cmi_fault;
  assign w_activity   = cmi_rdy || cmi_fault || marker_st;
  assign w_timeout    = w_live && !w_activity && (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_hunt_done  = (r_state == ST_HUNT) && w_good && (r_good_run == 4'(UP_CNT - 1));
  assign w_fault_down = (r_state == ST_UP) && w_fault && (r_fault_run == 4'(DOWN_FAULTS - 1));

  assign w_push  = (r_state == ST_UP) && w_good;
  assign w_pop   = !w_empty && out_ready;
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_flush = !en || (r_state == ST_RESYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_OFF;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (!en) begin
      w_state_nx = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:    w_state_nx = ST_RESYNC;
        ST_RESYNC: if (r_rs_cnt) w_state_nx = ST_HUNT;
        ST_HUNT: begin
          if (w_timeout)        w_state_nx = ST_RESYNC;
          else if (w_hunt_done) w_state_nx = ST_UP;
        end
        ST_UP:     if (w_timeout || w_fault_down) w_state_nx = ST_RESYNC;
        default:   w_state_nx = ST_OFF;
      endcase
    end
  end

  always_comb begin
    rcv_rst    = (r_state == ST_OFF) || (r_state == ST_RESYNC);
    link_up    = (r_state == ST_UP);
    link_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_cnt       <= 1'b0;
      r_timer        <= '0;
      r_good_run     <= '0;
      r_fault_run    <= '0;
      r_link_timeout <= 1'b0;
    end else begin
      r_rs_cnt       <= en && (r_state == ST_RESYNC) && !r_rs_cnt;
      r_link_timeout <= w_timeout;
      if (!w_live || w_activity) r_timer <= '0;
      else                       r_timer <= r_timer + 1'b1;
      if (!w_live) begin
        r_good_run  <= '0;
        r_fault_run <= '0;
      end else if (w_fault) begin
        r_good_run <= '0;
        if (r_state == ST_UP) r_fault_run <= r_fault_run + 1'b1;
      end else if (w_good) begin
        if (r_state == ST_HUNT) r_good_run <= r_good_run + 1'b1;
        else                    r_fault_run <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good_cnt    <= '0;
      r_fault_cnt   <= '0;
      r_ovf_cnt     <= '0;
      r_last_marker <= '0;
    end else begin
      if (marker_st && (r_state != ST_OFF)) r_last_marker <= marker_type;
      if (clr_cnt) begin
        r_good_cnt  <= '0;
        r_fault_cnt <= '0;
        r_ovf_cnt   <= '0;
      end else begin
        if (w_push && !w_drop && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + 16'd1;
        if (w_fault && (r_fault_cnt != '1))          r_fault_cnt <= r_fault_cnt + 16'd1;
        if (w_drop && (r_ovf_cnt != '1))             r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

  assign w_in_pkt = '{head: cmi_head, data: cmi_data};

  cmi_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMI_PKT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (w_in_pkt),
    .i_pop   (w_pop),
    .o_rdata (w_head_pkt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid    = !w_empty;
  assign out_head     = w_head_pkt.head;
  assign out_data     = w_head_pkt.data;
  assign link_timeout = r_link_timeout;
  assign good_cnt     = r_good_cnt;
  assign fault_cnt    = r_fault_cnt;
  assign ovf_cnt      = r_ovf_cnt;
  assign last_marker  = r_last_marker;

endmodule
`default_nettype wire

// File: tb/tb_cmi_link_sup.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmi_link_sup
// Brief    : Self-checking bench for cmi_link_sup against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_cmi_link_sup;

  localparam int UPC   = 4;
  localparam int DOWN  = 3;
  localparam int TO    = 100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr_cnt, cmi_rdy, cmi_fault, marker_st, out_ready;
  logic [7:0]  cmi_head;
  logic [63:0] cmi_data;
  logic [1:0]  marker_type;
  logic        rcv_rst, out_valid, link_up, link_timeout;
  logic [7:0]  out_head, ovf_cnt;
  logic [63:0] out_data;
  logic [1:0]  link_state, last_marker;
  logic [15:0] good_cnt, fault_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: link state as 0..3, FIFO as a queue, counters as ints.
  int          m_state, m_rs_left, m_good_run, m_fault_run, m_idle;
  int          m_good, m_fault, m_ovf, m_marker;
  bit          m_to;
  logic [71:0] m_q[$];

  always #5 clk = ~clk;

  cmi_link_sup #(
    .UP_CNT      (UPC),
    .DOWN_FAULTS (DOWN),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr_cnt      (clr_cnt),
    .cmi_rdy      (cmi_rdy),
    .cmi_fault    (cmi_fault),
    .cmi_head     (cmi_head),
    .cmi_data     (cmi_data),
    .marker_st    (marker_st),
    .marker_type  (marker_type),
    .rcv_rst      (rcv_rst),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_head     (out_head),
    .out_data     (out_data),
    .link_up      (link_up),
    .link_state   (link_state),
    .link_timeout (link_timeout),
    .good_cnt     (good_cnt),
    .fault_cnt    (fault_cnt),
    .ovf_cnt      (ovf_cnt),
    .last_marker  (last_marker)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rs_left = 0; m_good_run = 0; m_fault_run = 0; m_idle = 0;
    m_good = 0; m_fault = 0; m_ovf = 0; m_marker = 0; m_to = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int nx;
    bit live, f, g, act, pop;
    nx   = m_state;
    m_to = 0;
    live = en && (m_state >= 2);
    f    = live && cmi_fault;
    g    = live && cmi_rdy && !cmi_fault;
    act  = cmi_rdy || cmi_fault || marker_st;
    pop  = (m_q.size() > 0) && out_ready;
    if (marker_st && m_state != 0) m_marker = marker_type;
    if (!en || m_state == 1) m_q.delete();
    else if (pop) void'(m_q.pop_front());
    if (f && m_fault < 65535) m_fault++;
    if (!en) nx = 0;
    else if (m_state == 0) nx = 1;
    else if (m_state == 1) begin
      m_rs_left--;
      if (m_rs_left == 0) nx = 2;
    end else begin
      m_idle = act ? 0 : m_idle + 1;
      if (m_idle == TO) begin
        m_to = 1;
        nx   = 1;
      end else if (f) begin
        if (m_state == 2) m_good_run = 0;
        else begin
          m_fault_run++;
          if (m_fault_run == DOWN) nx = 1;
        end
      end else if (g) begin
        if (m_state == 2) begin
          m_good_run++;
          if (m_good_run == UPC) nx = 3;
        end else begin
          m_fault_run = 0;
          if (m_q.size() < DEPTH) begin
            m_q.push_back({cmi_head, cmi_data});
            if (m_good < 65535) m_good++;
          end else if (m_ovf < 255) m_ovf++;
        end
      end
    end
    if (nx == 1 && m_state != 1) m_rs_left = 2;
    if (nx < 2) begin
      m_good_run = 0; m_fault_run = 0; m_idle = 0;
    end
    if (clr_cnt) begin
      m_good = 0; m_fault = 0; m_ovf = 0;
    end
    m_state = nx;
  endtask

  task automatic check_all();
    chk("state", 72'(link_state), 72'(m_state));
    chk("rcv_rst", 72'(rcv_rst), 72'(m_state < 2));
    chk("link_up", 72'(link_up), 72'(m_state == 3));
    chk("out_valid", 72'(out_valid), 72'(m_q.size() > 0));
    if (m_q.size() > 0) chk("out_pkt", {out_head, out_data}, m_q[0]);
    chk("link_timeout", 72'(link_timeout), 72'(m_to));
    chk("good_cnt", 72'(good_cnt), 72'(m_good));
    chk("fault_cnt", 72'(fault_cnt), 72'(m_fault));
    chk("ovf_cnt", 72'(ovf_cnt), 72'(m_ovf));
    chk("last_marker", 72'(last_marker), 72'(m_marker));
  endtask

  // One clock: model follows the same edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    cmi_rdy = 0; cmi_fault = 0; marker_st = 0; clr_cnt = 0;
  endtask

  task automatic send_good(input logic [7:0] h, input logic [63:0] d);
    cmi_rdy = 1; cmi_head = h; cmi_data = d;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 0; en = 0; clr_cnt = 0; cmi_rdy = 0; cmi_fault = 0; marker_st = 0;
    marker_type = 0; cmi_head = 0; cmi_data = 0; out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1;
    cyc();

    // Bring-up: two RESYNC cycles, then HUNT with decoder released.
    en = 1;
    cyc(); chk("rs_c1_state", 72'(link_state), 72'd1); chk("rs_c1_rst", 72'(rcv_rst), 72'd1);
    cyc(); chk("rs_c2_rst", 72'(rcv_rst), 72'd1);
    cyc(); chk("hunt_c3_state", 72'(link_state), 72'd2); chk("hunt_c3_rst", 72'(rcv_rst), 72'd0);

    for (int i = 0; i < UPC; i++) send_good(8'(i), {$urandom, $urandom});
    chk("up_after_hunt", 72'(link_up), 72'd1);
    chk("hunt_no_valid", 72'(out_valid), 72'd0);
    chk("hunt_no_good", 72'(good_cnt), 72'd0);

    send_good(8'hA5, 64'h0004_0003_0002_0001);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 72'(out_valid), 72'd1);
      chk("hold_pkt", {out_head, out_data}, {8'hA5, 64'h0004_0003_0002_0001});
      cyc();
    end
    out_ready = 1; cyc(); out_ready = 0;
    chk("pop_valid", 72'(out_valid), 72'd0);

    clr_cnt = 1; cyc();
    for (int i = 0; i < 6; i++) send_good(8'(8'h10 + i), {16'(i), 16'(i), 16'(i), 16'(i)});
    chk("ovf_two", 72'(ovf_cnt), 72'd2);
    chk("good_four", 72'(good_cnt), 72'd4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("order_head", 72'(out_head), 72'(8'h10 + i));
      cyc();
    end
    out_ready = 0;
    chk("drained", 72'(out_valid), 72'd0);

    clr_cnt = 1; cyc();
    for (int i = 0; i < DOWN; i++) begin cmi_fault = 1; cyc(); end
    chk("down_state", 72'(link_state), 72'd1);
    chk("down_faults", 72'(fault_cnt), 72'd3);
    cyc(); cyc();
    for (int i = 0; i < UPC; i++) send_good(8'(i), 64'(i));
    cmi_fault = 1; cyc(); cmi_fault = 1; cyc();
    send_good(8'h77, 64'h77);
    cmi_fault = 1; cyc();
    chk("run_broken_up", 72'(link_up), 72'd1);

    // Silence in UP; a marker halfway restarts the idle window.
    repeat (50) cyc();
    marker_st = 1; marker_type = 2'd2; cyc();
    chk("marker_two", 72'(last_marker), 72'd2);
    n = 0;
    while (!link_timeout && n < 200) begin cyc(); n++; end
    chk("timeout_cycles", 72'(n), 72'd100);
    chk("timeout_resync", 72'(link_state), 72'd1);

    for (int i = 0; i < 4000; i++) begin
      int p_rdy, p_flt;
      p_rdy = ((i / 500) % 2 == 1) ? 1 : 35;
      p_flt = ((i / 500) % 2 == 1) ? 0 : 6;
      en          = ($urandom_range(0, 399) != 0);
      cmi_rdy     = ($urandom_range(0, 99) < p_rdy);
      cmi_fault   = ($urandom_range(0, 99) < p_flt);
      marker_st   = ($urandom_range(0, 99) < 2);
      marker_type = 2'($urandom_range(0, 3));
      cmi_head    = 8'($urandom);
      cmi_data    = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 99) < 40);
      clr_cnt     = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmi_link_sup.md
# cmi_link_sup

Link supervisor and packet scheduler for the CMI receive path. It sequences the CMI packet decoder: holds it in reset while the link is disabled or being resynchronised, and qualifies the link as up or down from the decoder's ready, fault and marker pulses. Once the link is up it buffers accepted packets in a small FIFO and presents them to one downstream consumer over a valid/ready handshake. It also keeps saturating link statistics for the register block.

## Interface
Parameters:
- UP_CNT, 4: consecutive good packets needed in HUNT to declare the link up (1..15).
- DOWN_FAULTS, 3: consecutive faults in UP that force RESYNC (1..15).
- TIMEOUT_CYC, 1000000: clock cycles without line activity in HUNT/UP before RESYNC.
- FIFO_DEPTH, 4: packet FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  link enable, level.
- clr_cnt  in  1  single-cycle pulse that clears the statistics counters.
- cmi_rdy  in  1  decoder packet-valid pulse.
- cmi_fault  in  1  decoder packet-error pulse.
- cmi_head  in  8  decoded header, valid with cmi_rdy.
- cmi_data  in  64  {data3,data2,data1,data0}, valid with cmi_rdy.
- marker_st  in  1  marker pulse.
- marker_type  in  2  marker type, valid with marker_st.
- rcv_rst  out  1  active-high reset to the decoder.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_head  out  8  head packet header.
- out_data  out  64  head packet data.
- link_up  out  1  state == UP.
- link_state  out  2  OFF=0, RESYNC=1, HUNT=2, UP=3.
- link_timeout  out  1  one-cycle pulse when the timeout fires.
- good_cnt  out  16  packets pushed, saturating.
- fault_cnt  out  16  faults in HUNT or UP, saturating.
- ovf_cnt  out  8  packets dropped because the FIFO was full, saturating.
- last_marker  out  2  type of the most recent marker.

## Operation
- Reset values: state OFF, rcv_rst=1, out_valid=0, all counters, last_marker and link_timeout 0, FIFO empty.
- OFF: rcv_rst=1. When en=1, go to RESYNC.
- RESYNC: rcv_rst=1 for exactly 2 cycles, FIFO flushed, timer and run counters cleared, then go to HUNT.
- HUNT: rcv_rst=0.
  - cmi_rdy increments the consecutive-good count; the packet is discarded and does not change good_cnt.
  - cmi_fault zeroes the consecutive-good count and increments fault_cnt.
  - Go to UP in the cycle the consecutive-good count reaches UP_CNT; the qualifying packet is not pushed.
- UP:
  - cmi_rdy pushes {head,data} into the FIFO, increments good_cnt and zeroes the consecutive-fault count.
  - cmi_fault increments fault_cnt and the consecutive-fault count. Reaching DOWN_FAULTS sends the block to RESYNC.
- Timer: cleared by cmi_rdy, cmi_fault or marker_st. When it reaches TIMEOUT_CYC in HUNT or UP, pulse link_timeout and go to RESYNC.
- marker_st latches last_marker=marker_type in any state except OFF. Markers do not affect the link counts.
- en=0 in any state: go to OFF next cycle and flush the FIFO. en has priority over all other transitions.
- If cmi_rdy and cmi_fault arrive in the same cycle, the fault wins and the packet is discarded.
- FIFO full and push without pop: drop the packet and increment ovf_cnt. Full with push and pop in the same cycle: both proceed.
- Counters saturate at all-ones. clr_cnt wins over a simultaneous increment.

## Timing
- Push on cycle N (FIFO empty): out_valid=1 and data visible from cycle N+1.
- Pop occurs when out_valid&&out_ready at a clock edge. out_head and out_data are held stable while out_valid=1 and out_ready=0.
- en rising at edge N: RESYNC at N+1..N+2, HUNT from N+3, rcv_rst deasserts at N+3.
- State changes, link_up and rcv_rst are registered one cycle after their cause.
- Timer width is clog2(TIMEOUT_CYC+1).

## Structure
- cmi_pkg:
  - link-state enum (OFF/RESYNC/HUNT/UP).
  - CMI_PKT_W=72.
  - packed packet struct {head[7:0], data[63:0]}.
- Sub-module cmi_pkt_fifo: synchronous FIFO parameterised by depth and width, with flush, full/empty, and simultaneous push/pop allowed when full.
- cmi_link_sup contains the FSM, timer, run counters and statistics.

## Test plan
- Reset, then en=1 -> rcv_rst high for 2 cycles after the OFF->RESYNC edge; link_state=2 at cycle 3.
- In HUNT, 4 cmi_rdy pulses -> link_up=1 the cycle after the 4th; out_valid stays 0 and good_cnt=0.
- In UP, push head=0xA5 with data 0x0004_0003_0002_0001 while out_ready=0 -> out_valid=1 next cycle and the data is held; out_ready=1 pops it and out_valid drops.
- In UP, send 6 packets with out_ready=0 (depth 4) -> ovf_cnt=2 and the 4 oldest are delivered in order.
- In UP, 3 consecutive cmi_fault pulses -> RESYNC and fault_cnt=3. A good packet between faults 2 and 3 resets the run, so the link stays up.
- TIMEOUT_CYC=100, silence in UP -> link_timeout pulses at 100 idle cycles, then RESYNC. A marker_st with type 2 at cycle 50 restarts the timer and sets last_marker=2.
